// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency byte-lane data memory responder for the MEM stage
// One request in flight; loads and stores resolve at the edge entering RESP.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, enter_resp, commit;
  logic        q_read, q_write;
  logic [2:0]  q_f3;
  logic [31:0] q_addr, q_wdata;
  logic        cur_read, cur_write;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr, cur_wdata;
  logic        f3_ok, misalign, out_of_range, err;
  logic [AW-1:0] word;
  logic [31:0] word_rd, shifted, load_data, sdata;
  logic [3:0]  be;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (LATENCY == 1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
          cnt_nxt    = 4'd0;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = LAT_M1;
        end
      end
      WAIT: if (cnt == 4'd1) begin
        state_nxt  = RESP;
        enter_resp = 1'b1;
        cnt_nxt    = 4'd0;
      end else begin
        cnt_nxt = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY=1 the request resolves on its accepting edge, so use the live inputs in IDLE.
  always_comb begin
    cur_read  = (state == IDLE) ? req_read   : q_read;
    cur_write = (state == IDLE) ? req_write  : q_write;
    cur_f3    = (state == IDLE) ? req_funct3 : q_f3;
    cur_addr  = (state == IDLE) ? req_addr   : q_addr;
    cur_wdata = (state == IDLE) ? req_wdata  : q_wdata;
  end

  always_comb begin
    f3_ok        = cur_write ? (cur_f3 inside {3'b000, 3'b001, 3'b010})
                             : (cur_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign     = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                   ((cur_f3 == 3'b010) && (cur_addr[1:0] != 2'b00));
    out_of_range = {2'b00, cur_addr[31:2]} >= DEPTH_U;
    err          = (cur_read == cur_write) | ~f3_ok | misalign | out_of_range;
    word         = cur_addr[AW+1:2];
    word_rd      = mem[word];
    shifted      = word_rd >> {cur_addr[1:0], 3'b000};
    case (cur_f3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
    case (cur_f3[1:0])
      2'b00:   begin be = 4'b0001 << cur_addr[1:0]; sdata = {4{cur_wdata[7:0]}};  end
      2'b01:   begin be = 4'b0011 << cur_addr[1:0]; sdata = {2{cur_wdata[15:0]}}; end
      default: begin be = 4'b1111;                  sdata = cur_wdata;            end
    endcase
    commit = enter_resp & cur_write & ~err & rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      q_read    <= 1'b0;
      q_write   <= 1'b0;
      q_f3      <= 3'd0;
      q_addr    <= 32'd0;
      q_wdata   <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        q_read  <= req_read;
        q_write <= req_write;
        q_f3    <= req_funct3;
        q_addr  <= req_addr;
        q_wdata <= req_wdata;
      end
      if (enter_resp) begin
        rsp_err   <= err;
        rsp_rdata <= (err || cur_write) ? 32'd0 : load_data;
      end
    end
  end

  // Array has no reset; only legal stores reaching RESP modify it.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word][8*i +: 8] <= sdata[8*i +: 8];
      end
    end
  end

endmodule
